// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - request/response bundle between execute-stage controller and the MDU
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (
        output start, op, reg_a, reg_b,
        input  busy, done, div_by_zero, result_hi, result_lo
    );

    modport slave (
        input  start, op, reg_a, reg_b,
        output busy, done, div_by_zero, result_hi, result_lo
    );
endinterface

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               dz_q, dz_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] product;

    always_comb begin
        op_signed = ~bus.op[0];
        op_div    = bus.op[1];
        a_neg     = op_signed & bus.reg_a[WIDTH-1];
        b_neg     = op_signed & bus.reg_b[WIDTH-1];
        a_mag     = a_neg ? -bus.reg_a : bus.reg_a;
        b_mag     = b_neg ? -bus.reg_b : bus.reg_b;

        // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
        product   = (sa_q ^ sb_q) ? -acc_q : acc_q;

        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_CALC;
                    count_d  = '0;
                    is_div_d = op_div;
                    sa_d     = a_neg;
                    sb_d     = b_neg;
                    dz_d     = op_div && (bus.reg_b == '0);
                    acc_d    = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                    b_d      = op_div ? b_mag : a_mag;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    if (!div_trial[WIDTH])
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1))
                    state_d = S_FIXUP;
            end
            S_FIXUP: begin
                if (is_div_q) begin
                    // with b=0 the remainder path reproduces |a|, so sign-fixing it restores a
                    hi_d = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = dz_q ? {WIDTH{1'b1}}
                                : ((sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                end else begin
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end
                dbz_d   = dz_q;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.result_hi   = hi_q;
    assign bus.result_lo   = lo_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - directed table-driven bench for mdu_iterative
module tb_mdu_iterative;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(W)) bus();
    mdu_iterative #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        string          name;
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   hi;
        logic [W-1:0]   lo;
        logic           dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input logic [W-1:0] ph, input logic [W-1:0] pl);
        int first, ndone, busy_bad, hold_bad;
        logic [W-1:0] chi, clo;
        logic cdz;
        first = 0; ndone = 0; busy_bad = 0; hold_bad = 0;
        chi = '0; clo = '0; cdz = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = v.op; bus.reg_a = v.a; bus.reg_b = v.b;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.op = ~v.op; bus.reg_a = ~v.a; bus.reg_b = v.b + 1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first == 0) begin
                    first = c; chi = bus.result_hi; clo = bus.result_lo; cdz = bus.div_by_zero;
                end
            end
            if ((c <= W + 2) != bus.busy) busy_bad++;
            if (c < W + 2 && (bus.result_hi !== ph || bus.result_lo !== pl)) hold_bad++;
        end
        chk({v.name, " done_cycle"}, 64'(first), 64'(W + 2));
        chk({v.name, " done_width"}, 64'(ndone), 64'd1);
        chk({v.name, " busy_window"}, 64'(busy_bad), 64'd0);
        chk({v.name, " hilo_hold"}, 64'(hold_bad), 64'd0);
        chk({v.name, " hi"}, 64'(chi), 64'(v.hi));
        chk({v.name, " lo"}, 64'(clo), 64'(v.lo));
        chk({v.name, " div_by_zero"}, 64'(cdz), 64'(v.dbz));
    endtask

    initial begin
        int nd, d1, d2;
        logic [W-1:0] lo1, hi1, lo2, hi2;
        logic [W-1:0] ph, pl;

        vecs[0]  = '{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{"mult_m3x5",   2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{"mult_m4xm4",  2'b00, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'd16,       1'b0};
        vecs[3]  = '{"div_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{"divu_7_2",    2'b11, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
        vecs[5]  = '{"div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
        vecs[6]  = '{"div_m100_0",  2'b10, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{"divu_1234_0", 2'b11, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{"multu_2x3",   2'b01, 32'd2,        32'd3,        32'h0,        32'd6,        1'b0};
        vecs[9]  = '{"div_100_m7",  2'b10, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0};
        vecs[10] = '{"mult_minsq",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};
        vecs[11] = '{"divu_100_7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};

        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.reg_a = '0; bus.reg_b = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset dbz", 64'(bus.div_by_zero), 64'd0);
        chk("reset hi", 64'(bus.result_hi), 64'd0);
        chk("reset lo", 64'(bus.result_lo), 64'd0);
        rst = 1'b0;

        ph = '0; pl = '0;
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], ph, pl);
            ph = vecs[i].hi; pl = vecs[i].lo;
        end

        // starts during busy/DONE are dropped; the one right after DONE is taken
        nd = 0; d1 = 0; d2 = 0; lo1 = '0; hi1 = '0; lo2 = '0; hi2 = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.reg_a = 32'd5; bus.reg_b = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                if (d1 == 0) begin
                    d1 = c; lo1 = bus.result_lo; hi1 = bus.result_hi;
                end else if (d2 == 0) begin
                    d2 = c; lo2 = bus.result_lo; hi2 = bus.result_hi;
                end
            end
            case (c)
                5:  begin bus.start = 1'b1; bus.op = 2'b11; bus.reg_a = 32'hFFFF; bus.reg_b = 32'd0; end
                6:  bus.start = 1'b0;
                34: begin bus.start = 1'b1; bus.op = 2'b01; bus.reg_a = 32'd9;  bus.reg_b = 32'd9;  end
                35: begin bus.reg_a = 32'd11; bus.reg_b = 32'd11; end
                36: bus.start = 1'b0;
                default: ;
            endcase
        end
        chk("ignore done_count", 64'(nd), 64'd2);
        chk("ignore first_done", 64'(d1), 64'd34);
        chk("ignore first_lo", 64'(lo1), 64'd35);
        chk("ignore first_hi", 64'(hi1), 64'd0);
        chk("b2b second_done", 64'(d2), 64'd69);
        chk("b2b second_lo", 64'(lo2), 64'd121);
        chk("b2b second_hi", 64'(hi2), 64'd0);

        // reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.reg_a = 32'd100; bus.reg_b = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort done", 64'(bus.done), 64'd0);
        chk("abort hi", 64'(bus.result_hi), 64'd0);
        chk("abort lo", 64'(bus.result_lo), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("abort no_done", 64'(nd), 64'd0);
        run_vec(vecs[11], '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
